// File: rtl/mips_cpu_offset_pipe_if.sv
// Bundle between the address-calculation stage and the offset delay pipe.
// The bypass signal only exists when OFFSET_PIPE_BYPASS_EN is defined.
interface mips_cpu_offset_pipe_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             wr_en;
    logic             stall;
    logic             flush;
    logic [WIDTH-1:0] data_in;
    logic [1:0]       size_in;
`ifdef OFFSET_PIPE_BYPASS_EN
    logic             bypass;
`endif
    logic [WIDTH-1:0] data_out;
    logic [1:0]       size_out;
    logic             valid_out;
    logic [3:0]       byte_en_out;
    logic             misaligned_out;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output wr_en, stall, flush, data_in, size_in,
`ifdef OFFSET_PIPE_BYPASS_EN
        output bypass,
`endif
        input  data_out, size_out, valid_out, byte_en_out, misaligned_out, occupancy
    );

    modport slave (
        input  wr_en, stall, flush, data_in, size_in,
`ifdef OFFSET_PIPE_BYPASS_EN
        input  bypass,
`endif
        output data_out, size_out, valid_out, byte_en_out, misaligned_out, occupancy
    );
endinterface

// File: rtl/mips_cpu_offset_pipe.sv
// Delay pipe carrying byte offset and access size to the memory stage, with byte-lane decode.
// Optional zero-latency bypass enabled by defining OFFSET_PIPE_BYPASS_EN.
module mips_cpu_offset_pipe #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mips_cpu_offset_pipe_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] w_valid_nxt;
    logic [OCC_W-1:0] w_occ_nxt;
    logic [OCC_W-1:0] r_occ;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             r_valid;
            logic [WIDTH-1:0] r_data;
            logic [1:0]       r_size;
            logic             w_src_valid;
            logic [WIDTH-1:0] w_src_data;
            logic [1:0]       w_src_size;

            if (gi == 0) begin : g_head
                // Bubbles enter with data/size zeroed so downstream stages never hold stale payload.
                assign w_src_valid = bus.wr_en;
                assign w_src_data  = bus.wr_en ? bus.data_in : '0;
                assign w_src_size  = bus.wr_en ? bus.size_in : 2'b00;
            end else begin : g_tail
                assign w_src_valid = g_stage[gi-1].r_valid;
                assign w_src_data  = g_stage[gi-1].r_data;
                assign w_src_size  = g_stage[gi-1].r_size;
            end

            assign w_valid_nxt[gi] = bus.flush ? 1'b0 : (bus.stall ? r_valid : w_src_valid);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_size  <= 2'b00;
                end else if (bus.flush) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_size  <= 2'b00;
                end else if (!bus.stall) begin
                    r_valid <= w_src_valid;
                    r_data  <= w_src_data;
                    r_size  <= w_src_size;
                end
            end
        end
    endgenerate

    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
        end
    end

    // Occupancy tracks the post-edge valid bits, so it is computed from next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    logic             w_out_valid;
    logic [WIDTH-1:0] w_out_data;
    logic [1:0]       w_out_size;

`ifdef OFFSET_PIPE_BYPASS_EN
    logic w_byp;
    assign w_byp       = bus.bypass & ~bus.flush & ~bus.stall;
    assign w_out_valid = w_byp ? bus.wr_en   : g_stage[DEPTH-1].r_valid;
    assign w_out_data  = w_byp ? bus.data_in : g_stage[DEPTH-1].r_data;
    assign w_out_size  = w_byp ? bus.size_in : g_stage[DEPTH-1].r_size;
`else
    assign w_out_valid = g_stage[DEPTH-1].r_valid;
    assign w_out_data  = g_stage[DEPTH-1].r_data;
    assign w_out_size  = g_stage[DEPTH-1].r_size;
`endif

    logic [1:0] w_off;
    logic [3:0] w_byte_en;
    logic       w_misaligned;

    assign w_off = w_out_data[1:0];

    // Byte enables are still produced on a misaligned access; the consumer masks them.
    always_comb begin
        w_byte_en    = 4'b0000;
        w_misaligned = 1'b0;
        if (w_out_valid) begin
            case (w_out_size)
                2'b00: begin
                    w_byte_en    = 4'b0001 << w_off;
                    w_misaligned = 1'b0;
                end
                2'b01: begin
                    w_byte_en    = w_off[1] ? 4'b1100 : 4'b0011;
                    w_misaligned = w_off[0];
                end
                2'b10: begin
                    w_byte_en    = 4'b1111;
                    w_misaligned = (w_off != 2'b00);
                end
                default: begin
                    w_byte_en    = 4'b0000;
                    w_misaligned = 1'b1;
                end
            endcase
        end
    end

    assign bus.data_out       = w_out_data;
    assign bus.size_out       = w_out_size;
    assign bus.valid_out      = w_out_valid;
    assign bus.byte_en_out    = w_byte_en;
    assign bus.misaligned_out = w_misaligned;
    assign bus.occupancy      = r_occ;
endmodule
